// File: rtl/point_mult_ladder.sv
// Montgomery-ladder scalar multiplier R = k*P over point_add / point_double.
// The package carries the point type and the field-level add.

package point_mult_pkg;
  localparam int FIELD_W = 16;
  localparam logic [FIELD_W-1:0] P_MOD = 16'd65521;

  typedef struct packed {
    logic [FIELD_W-1:0] x;
    logic [FIELD_W-1:0] y;
  } curve_point_t;

  // (a + b) mod P_MOD for a, b < P_MOD; a carry out still reduces correctly mod 2^FIELD_W
  function automatic logic [FIELD_W-1:0] mod_add(input logic [FIELD_W-1:0] a,
                                                 input logic [FIELD_W-1:0] b);
    logic [FIELD_W-1:0] s;
    logic               c;
    {c, s} = {1'b0, a} + {1'b0, b};
    return (c || (s >= P_MOD)) ? (s - P_MOD) : s;
  endfunction
endpackage

// Point add primitive: group law is component-wise modular addition.
// done pulses exactly LAT cycles after the cycle Reset is held high.
module point_add import point_mult_pkg::*; #(
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         Reset,
  input  curve_point_t a,
  input  curve_point_t b,
  output logic         done,
  output curve_point_t sum
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  logic [CW-1:0] cnt;
  logic          fired;

  // latency countdown; fired keeps done to a single-cycle pulse
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt   <= CW'(LAT - 1);
      fired <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      fired <= 1'b1;
    end
  end

  assign done  = (cnt == '0) && !fired;
  assign sum.x = mod_add(a.x, b.x);
  assign sum.y = mod_add(a.y, b.y);
endmodule

// Point double primitive, same handshake as point_add.
module point_double import point_mult_pkg::*; #(
  parameter int LAT = 5
) (
  input  logic         clk,
  input  logic         Reset,
  input  curve_point_t a,
  output logic         done,
  output curve_point_t dbl
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  logic [CW-1:0] cnt;
  logic          fired;

  // latency countdown; fired keeps done to a single-cycle pulse
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt   <= CW'(LAT - 1);
      fired <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      fired <= 1'b1;
    end
  end

  assign done  = (cnt == '0) && !fired;
  assign dbl.x = mod_add(a.x, a.x);
  assign dbl.y = mod_add(a.y, a.y);
endmodule

// state  | meaning
// IDLE   | waiting for start, capturing k and P
// SCAN   | skipping leading zero bits of k (SKIP_LEADING only)
// KICK   | one-cycle reset of both primitives, latches cleared
// WAIT   | collecting add/double done pulses
// UPDATE | ladder swap into R0/R1, step to next bit
// FINISH | result valid, done pulse
module point_mult_ladder import point_mult_pkg::*; #(
  parameter int KEY_W        = 256,
  parameter bit SKIP_LEADING = 1'b0,
  parameter int ADD_LAT      = 3,
  parameter int DBL_LAT      = 5
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [KEY_W-1:0] scalar,
  input  curve_point_t     in_point,
  input  logic             in_inf,
  output logic             busy,
  output logic             done,
  output curve_point_t     out_point,
  output logic             out_inf
);
  localparam int IW = $clog2(KEY_W);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_KICK, S_WAIT, S_UPDATE, S_FINISH} state_t;
  state_t state_q, state_d;

  curve_point_t     r0_pt, r1_pt, r0_nxt_pt, r1_nxt_pt, dbl_op, add_res, dbl_res, sum_pt, dbl_pt;
  logic             r0_inf, r1_inf, r0_nxt_inf, r1_nxt_inf, dbl_op_inf, sum_inf, dbl_inf;
  logic [KEY_W-1:0] k_reg;
  logic [IW-1:0]    idx;
  logic             add_seen, dbl_seen, add_done, dbl_done, kick_q, prim_rst, cur_bit;

  assign cur_bit    = k_reg[idx];
  assign dbl_op     = cur_bit ? r1_pt  : r0_pt;
  assign dbl_op_inf = cur_bit ? r1_inf : r0_inf;
  // kick_q is a flop, so the primitive reset is glitch-free
  assign prim_rst   = Reset | kick_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH);

  point_add #(.LAT(ADD_LAT)) u_add (
    .clk(clk), .Reset(prim_rst), .a(r0_pt), .b(r1_pt), .done(add_done), .sum(add_res)
  );

  point_double #(.LAT(DBL_LAT)) u_dbl (
    .clk(clk), .Reset(prim_rst), .a(dbl_op), .done(dbl_done), .dbl(dbl_res)
  );

  // state register plus the registered primitive kick
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      kick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kick_q  <= (state_d == S_KICK);
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = SKIP_LEADING ? S_SCAN : S_KICK;
      S_SCAN:   if (cur_bit) state_d = S_KICK;
                else if (idx == '0) state_d = S_FINISH;
      S_KICK:   state_d = S_WAIT;
      S_WAIT:   if ((add_seen || add_done) && (dbl_seen || dbl_done)) state_d = S_UPDATE;
      S_UPDATE: state_d = (idx == '0) ? S_FINISH : S_KICK;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // infinity bypass of primitive results and the ladder swap
  always_comb begin
    sum_pt  = add_res;
    sum_inf = 1'b0;
    if (r0_inf && r1_inf) begin
      sum_pt  = '0;
      sum_inf = 1'b1;
    end else if (r0_inf) begin
      sum_pt = r1_pt;
    end else if (r1_inf) begin
      sum_pt = r0_pt;
    end
    dbl_pt     = dbl_op_inf ? '0 : dbl_res;
    dbl_inf    = dbl_op_inf;
    r0_nxt_pt  = r0_pt;
    r0_nxt_inf = r0_inf;
    r1_nxt_pt  = r1_pt;
    r1_nxt_inf = r1_inf;
    if (state_q == S_UPDATE) begin
      if (cur_bit) begin
        r0_nxt_pt = sum_pt; r0_nxt_inf = sum_inf;
        r1_nxt_pt = dbl_pt; r1_nxt_inf = dbl_inf;
      end else begin
        r1_nxt_pt = sum_pt; r1_nxt_inf = sum_inf;
        r0_nxt_pt = dbl_pt; r0_nxt_inf = dbl_inf;
      end
    end
  end

  // capture, bit index, done latches, ladder registers and result
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      k_reg     <= '0;
      idx       <= '0;
      r0_pt     <= '0;
      r0_inf    <= 1'b0;
      r1_pt     <= '0;
      r1_inf    <= 1'b0;
      add_seen  <= 1'b0;
      dbl_seen  <= 1'b0;
      out_point <= '0;
      out_inf   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          k_reg  <= scalar;
          r0_pt  <= '0;
          r0_inf <= 1'b1;
          r1_pt  <= in_point;
          r1_inf <= in_inf;
          idx    <= IW'(KEY_W - 1);
        end
        S_SCAN: if (!cur_bit && (idx != '0)) idx <= idx - 1'b1;
        S_KICK: begin
          add_seen <= 1'b0;
          dbl_seen <= 1'b0;
        end
        S_WAIT: begin
          add_seen <= add_seen | add_done;
          dbl_seen <= dbl_seen | dbl_done;
        end
        S_UPDATE: begin
          r0_pt  <= r0_nxt_pt;
          r0_inf <= r0_nxt_inf;
          r1_pt  <= r1_nxt_pt;
          r1_inf <= r1_nxt_inf;
          if (idx != '0) idx <= idx - 1'b1;
        end
        default: ;
      endcase
      // result is presented for the whole FINISH cycle
      if (state_d == S_FINISH) begin
        out_point <= r0_nxt_pt;
        out_inf   <= r0_nxt_inf;
      end
    end
  end
endmodule

// File: tb/tb_point_mult_ladder.sv
// Scoreboard bench: two ladders (constant-time and skip-leading) driven by the
// same stimulus, checked against k*P computed directly with modular arithmetic.
module tb_point_mult_ladder;
  import point_mult_pkg::*;

  localparam int     KW      = 16;
  localparam int     ADD_LAT = 3;
  localparam int     DBL_LAT = 5;
  localparam int     T       = (ADD_LAT > DBL_LAT) ? ADD_LAT : DBL_LAT;
  localparam longint PM      = 65521;

  logic          clk = 1'b0;
  logic          Reset, start, in_inf;
  logic [KW-1:0] scalar;
  curve_point_t  in_point;
  logic          busy0, done0, out_inf0, busy1, done1, out_inf1;
  curve_point_t  out0, out1;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        inf;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t last0, last1;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;

  point_mult_ladder #(.KEY_W(KW), .SKIP_LEADING(1'b0), .ADD_LAT(ADD_LAT), .DBL_LAT(DBL_LAT)) dut0 (
    .clk(clk), .Reset(Reset), .start(start), .scalar(scalar), .in_point(in_point), .in_inf(in_inf),
    .busy(busy0), .done(done0), .out_point(out0), .out_inf(out_inf0)
  );

  point_mult_ladder #(.KEY_W(KW), .SKIP_LEADING(1'b1), .ADD_LAT(ADD_LAT), .DBL_LAT(DBL_LAT)) dut1 (
    .clk(clk), .Reset(Reset), .start(start), .scalar(scalar), .in_point(in_point), .in_inf(in_inf),
    .busy(busy1), .done(done1), .out_point(out1), .out_inf(out_inf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lead_zeros(input logic [KW-1:0] k);
    int z = 0;
    for (int i = KW - 1; i >= 0; i--) begin
      if (k[i]) return z;
      z++;
    end
    return z;
  endfunction

  // k*P in the additive group, plus cycle count from the latency rules
  function automatic exp_t model(input logic [KW-1:0] k, input curve_point_t p,
                                 input logic inf, input bit skip, input int t0);
    exp_t e;
    int   z;
    e.inf = inf || (k == '0);
    e.x   = e.inf ? 16'd0 : 16'((longint'(k) * longint'(p.x)) % PM);
    e.y   = e.inf ? 16'd0 : 16'((longint'(k) * longint'(p.y)) % PM);
    z     = lead_zeros(k);
    if (!skip)          e.lat = KW * (2 + T) + 2;
    else if (k == '0)   e.lat = KW + 2;
    else                e.lat = 1 + (z + 1) + (KW - z) * (2 + T) + 1;
    e.t0 = t0;
    return e;
  endfunction

  task automatic cmp_res(input string tag, input exp_t e, input curve_point_t p,
                         input logic inf, input logic b);
    chk({tag, " x"}, 64'(p.x), 64'(e.x));
    chk({tag, " y"}, 64'(p.y), 64'(e.y));
    chk({tag, " inf"}, 64'(inf), 64'(e.inf));
    chk({tag, " latency"}, 64'(cyc - e.t0 + 1), 64'(e.lat));
    chk({tag, " busy at done"}, 64'(b), 64'd1);
  endtask

  // monitor: every done pulse pops and checks the oldest expectation
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut0 unexpected done: got 1 expected 0");
      end else begin
        last0 = q0.pop_front();
        cmp_res("dut0", last0, out0, out_inf0, busy0);
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut1 unexpected done: got 1 expected 0");
      end else begin
        last1 = q1.pop_front();
        cmp_res("dut1", last1, out1, out_inf1, busy1);
      end
    end
  end

  task automatic issue(input logic [KW-1:0] k, input curve_point_t p, input logic inf);
    @(posedge clk); #1;
    start = 1'b1; scalar = k; in_point = p; in_inf = inf;
    q0.push_back(model(k, p, inf, 1'b0, cyc));
    q1.push_back(model(k, p, inf, 1'b1, cyc));
    @(posedge clk); #1;
    start    = 1'b0;
    scalar   = 16'($urandom);
    in_point = {16'($urandom), 16'($urandom)};
    in_inf   = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (((q0.size() != 0) || (q1.size() != 0)) && (n < 2000)) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 2000) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout waiting for done: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      q0.delete(); q1.delete();
    end else begin
      chk("busy0 after done", 64'(busy0), 64'd0);
      chk("busy1 after done", 64'(busy1), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("dut0 hold x", 64'(out0.x), 64'(last0.x));
      chk("dut0 hold inf", 64'(out_inf0), 64'(last0.inf));
      chk("dut1 hold y", 64'(out1.y), 64'(last1.y));
      chk("dut1 hold inf", 64'(out_inf1), 64'(last1.inf));
    end
  endtask

  function automatic curve_point_t rnd_pt();
    curve_point_t p;
    p.x = 16'($urandom_range(0, 65520));
    p.y = 16'($urandom_range(0, 65520));
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    curve_point_t pa;
    logic [KW-1:0] k;
    pa = '{x: 16'd4660, y: 16'd22136};
    Reset = 1'b1; start = 1'b0; scalar = '0; in_point = '0; in_inf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy0", 64'(busy0), 64'd0);
    chk("reset done0", 64'(done0), 64'd0);
    chk("reset out_inf0", 64'(out_inf0), 64'd1);
    chk("reset out0", 64'(out0), 64'd0);
    chk("reset busy1", 64'(busy1), 64'd0);
    chk("reset out_inf1", 64'(out_inf1), 64'd1);
    Reset = 1'b0;
    repeat (2) @(posedge clk);

    issue(16'd1, pa, 1'b0);      wait_idle();
    issue(16'd2, pa, 1'b0);      wait_idle();
    issue(16'hFFFF, pa, 1'b0);   wait_idle();
    issue(16'h8000, pa, 1'b0);   wait_idle();
    issue(16'd0, pa, 1'b0);      wait_idle();
    issue(16'd5, pa, 1'b1);      wait_idle();
    issue(16'h0001, '0, 1'b0);   wait_idle();

    for (int i = 0; i < 20; i++) begin
      k = 16'($urandom);
      if ($urandom_range(0, 2) == 0) k = k >> $urandom_range(1, 15);
      issue(k, rnd_pt(), ($urandom_range(0, 7) == 0));
      wait_idle();
    end

    // stray start while both ladders are busy must be ignored
    issue(16'hA5C3, pa, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1; scalar = 16'h5A3C; in_point = rnd_pt();
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // a finite result is on the outputs; reset while both are in WAIT
    issue(16'd1, pa, 1'b0);      wait_idle();
    issue(16'h8001, pa, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("abort busy0", 64'(busy0), 64'd0);
    chk("abort busy1", 64'(busy1), 64'd0);
    chk("abort out_inf0", 64'(out_inf0), 64'd1);
    chk("abort out_inf1", 64'(out_inf1), 64'd1);
    chk("abort out0", 64'(out0), 64'd0);
    chk("abort out1", 64'(out1), 64'd0);
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b0;
    repeat (150) @(posedge clk);
    issue(16'd1, pa, 1'b0);      wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
